// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 iterative, fixed 33-cycle latency (accept -> done).
// Optional macro MULDIV_DIV_EN enables the divide/remainder datapath; without it ops 1xx return 0.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out,
   output logic        reg_write
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [31:0] result_q, result_d;
   logic [2:0]  op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   logic        neg_res_q, neg_res_d, wr_en_q, wr_en_d;
`ifdef MULDIV_DIV_EN
   logic        neg_rem_q, neg_rem_d, div0_q, div0_d;
   logic [32:0] rem_sh, div_diff;
   logic        div_ge, unused_diff_msb;
`endif

   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [31:0] step_hi, step_lo, fin_res;
   logic [63:0] prod, prod_s;

   // MUL low word is sign-agnostic, so it runs as unsigned.
   assign a_neg = rs1_data[31] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
   assign b_neg = rs2_data[31] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
   assign a_mag = a_neg ? -rs1_data : rs1_data;
   assign b_mag = b_neg ? -rs2_data : rs2_data;

   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);

`ifdef MULDIV_DIV_EN
   assign rem_sh          = {hi_q, lo_q[31]};
   assign div_diff        = rem_sh - {1'b0, opnd_q};
   assign div_ge          = rem_sh >= {1'b0, opnd_q};
   assign unused_diff_msb = div_diff[32];
`endif

   always_comb begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], lo_q[31:1]};
`ifdef MULDIV_DIV_EN
      if (op_q[2]) begin
         step_hi = div_ge ? div_diff[31:0] : rem_sh[31:0];
         step_lo = {lo_q[30:0], div_ge};
      end
`endif
   end

   assign prod   = {step_hi, step_lo};
   assign prod_s = neg_res_q ? -prod : prod;

   always_comb begin
      fin_res = '0;
      case (op_q)
         3'b000:                 fin_res = prod_s[31:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_s[63:32];
`ifdef MULDIV_DIV_EN
         3'b100, 3'b101:         fin_res = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? -step_lo : step_lo);
         3'b110, 3'b111:         fin_res = neg_rem_q ? -step_hi : step_hi;
`endif
         default:                fin_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      opnd_d    = opnd_q;
      op_d      = op_q;
      rd_d      = rd_q;
      neg_res_d = neg_res_q;
      wr_en_d   = wr_en_q;
      result_d  = result_q;
`ifdef MULDIV_DIV_EN
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d   = CALC;
            cnt_d     = '0;
            op_d      = op;
            rd_d      = rd_in;
            neg_res_d = a_neg ^ b_neg;
            hi_d      = '0;
            lo_d      = b_mag;
            opnd_d    = a_mag;
`ifdef MULDIV_DIV_EN
            wr_en_d   = |rd_in;
            neg_rem_d = a_neg;
            div0_d    = (rs2_data == 32'd0);
            if (op[2]) begin
               lo_d   = a_mag;
               opnd_d = b_mag;
            end
`else
            wr_en_d   = (|rd_in) & ~op[2];
`endif
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            hi_d  = step_hi;
            lo_d  = step_lo;
            if (cnt_q == 5'd31) begin
               state_d  = DONE;
               result_d = fin_res;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opnd_q    <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         neg_res_q <= 1'b0;
         wr_en_q   <= 1'b0;
         result_q  <= '0;
`ifdef MULDIV_DIV_EN
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         opnd_q    <= opnd_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         neg_res_q <= neg_res_d;
         wr_en_q   <= wr_en_d;
         result_q  <= result_d;
`ifdef MULDIV_DIV_EN
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
`endif
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign rd_out    = rd_q;
   assign reg_write = done & wr_en_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with scoreboard, plus ignore/reset sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [2:0]  op;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_in;
   logic        busy, done, reg_write;
   logic [31:0] result;
   logic [4:0]  rd_out;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result), .rd_out(rd_out), .reg_write(reg_write)
   );

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        wr;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t vecs[20];

   function automatic logic [31:0] dres(input logic [31:0] x);
      return DIV_EN ? x : 32'd0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
      end
   endtask

   // Issues one op in the current cycle and follows it to completion; leaves the bench
   // in the first IDLE cycle so the caller may start again back-to-back.
   task automatic run_one(input vec_t v, input int idx);
      exp_t e;
      int   cyc;
      string nm;
      nm    = $sformatf("v%0d", idx);
      e.res = v.res;
      e.rd  = v.rd;
      e.wr  = (v.rd != 5'd0) && (!v.op[2] || DIV_EN);
      sb.push_back(e);
      op = v.op; rs1_data = v.a; rs2_data = v.b; rd_in = v.rd; start = 1'b1;
      @(negedge clk);
      start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; op = 3'($urandom); rd_in = 5'($urandom);
      cyc = 1;
      chk({nm, " busy"}, 32'(busy), 32'd1);
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, " latency"}, cyc, 33);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({nm, " result"}, result, e.res);
         chk({nm, " rd_out"}, 32'(rd_out), 32'(e.rd));
         chk({nm, " reg_write"}, 32'(reg_write), 32'(e.wr));
      end
      @(negedge clk);
      chk({nm, " idle_done"}, 32'(done), 32'd0);
      chk({nm, " idle_busy"}, 32'(busy), 32'd0);
      chk({nm, " held"}, result, e.res);
   endtask

   initial begin
      vecs[0]  = '{3'b000, 32'd7,         32'd6,         5'd5,  32'h0000_002A};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF};
      vecs[4]  = '{3'b000, 32'd3,         32'd3,         5'd0,  32'd9};
      vecs[5]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
      vecs[6]  = '{3'b011, 32'h8000_0000, 32'h0000_0002, 5'd4,  32'h0000_0001};
      vecs[7]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 5'd6,  32'h0000_0000};
      vecs[8]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'hFFFF_FFFF};
      vecs[9]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd8,  dres(32'hFFFF_FFFD)};
      vecs[10] = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd9,  dres(32'hFFFF_FFFF)};
      vecs[11] = '{3'b101, 32'd100,       32'd7,         5'd10, dres(32'd14)};
      vecs[12] = '{3'b111, 32'd100,       32'd7,         5'd11, dres(32'd2)};
      vecs[13] = '{3'b101, 32'd5,         32'd0,         5'd12, dres(32'hFFFF_FFFF)};
      vecs[14] = '{3'b110, 32'd5,         32'd0,         5'd13, dres(32'd5)};
      vecs[15] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, dres(32'h8000_0000)};
      vecs[16] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, dres(32'd0)};
      vecs[17] = '{3'b100, 32'hFFFF_FFF7, 32'd0,         5'd16, dres(32'hFFFF_FFFF)};
      vecs[18] = '{3'b110, 32'hFFFF_FFF7, 32'd0,         5'd17, dres(32'hFFFF_FFF7)};
      vecs[19] = '{3'b100, 32'd9,         32'd3,         5'd0,  dres(32'd3)};

      rst = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
      repeat (3) @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst reg_write", 32'(reg_write), 32'd0);
      chk("rst result", result, 32'd0);
      chk("rst rd_out", 32'(rd_out), 32'd0);

      // reset wins over a simultaneous start
      start = 1'b1; op = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; rd_in = 5'd1;
      @(negedge clk);
      chk("rst_prio busy", 32'(busy), 32'd0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 20; i++) run_one(vecs[i], i);

      // start pulsed mid-operation must be ignored
      begin
         int cyc, ndone;
         op = 3'b000; rs1_data = 32'd7; rs2_data = 32'd6; rd_in = 5'd5; start = 1'b1;
         @(negedge clk);
         start = 1'b0; cyc = 1; ndone = 0;
         while (cyc < 33) begin
            if (cyc == 5) begin
               op = 3'b011; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF; rd_in = 5'd9; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
            cyc++;
            if (done && cyc < 33) ndone++;
         end
         start = 1'b0;
         chk("ign early_done", 32'(ndone), 32'd0);
         chk("ign done", 32'(done), 32'd1);
         chk("ign result", result, 32'h0000_002A);
         chk("ign rd_out", 32'(rd_out), 32'd5);
         repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
         end
         chk("ign extra_done", 32'(ndone), 32'd0);
      end

      // reset mid-operation aborts, then restart the first cycle after
      begin
         int cyc, ndone;
         op = 3'b000; rs1_data = 32'd100; rs2_data = 32'd100; rd_in = 5'd3; start = 1'b1;
         @(negedge clk);
         start = 1'b0; cyc = 1; ndone = 0;
         while (cyc < 11) begin
            rst = (cyc == 10);
            @(negedge clk);
            cyc++;
            if (done || reg_write) ndone++;
         end
         rst = 1'b0;
         chk("abort busy", 32'(busy), 32'd0);
         chk("abort done", 32'(ndone), 32'd0);
         chk("abort result", result, 32'd0);
         chk("abort rd_out", 32'(rd_out), 32'd0);
         run_one('{3'b000, 32'd3, 32'd3, 5'd0, 32'd9}, 100);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
